// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one registered memory port between instruction fetch (I)
// and data load/store (D). D normally wins, but at most MAX_D_RUN back-to-back D grants
// are made while fetch waits, so fetch is never starved. Accesses that see no mem_ready
// for TIMEOUT cycles are aborted and acked with mem_err.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_D_RUN = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  // data side
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_err,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned RunW = (MAX_D_RUN < 1) ? 1 : $clog2(MAX_D_RUN + 1);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [RunW-1:0] RunMax  = RunW'(MAX_D_RUN);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [BeW-1:0]    mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              mem_err_q, mem_err_d;
  logic [RunW-1:0]   d_run_q, d_run_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // State and registered outputs; reset abandons any access in flight without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      mem_err_q   <= 1'b0;
      d_run_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      mem_err_q   <= mem_err_d;
      d_run_q     <= d_run_d;
      cnt_q       <= cnt_d;
    end
  end

  // Grant arbitration, completion and timeout; acks and mem_err default to a single pulse.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    mem_err_d   = 1'b0;
    d_run_d     = d_run_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        // The cycle carrying an ack is a turnaround: the requester has not yet dropped req.
        if (!(if_ack_q || dm_ack_q)) begin
          if (dm_req && (!if_req || (d_run_q < RunMax))) begin
            state_d     = StBusyD;
            mem_req_d   = 1'b1;
            mem_we_d    = dm_we;
            mem_be_d    = dm_be;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            cnt_d       = '0;
            if (!if_req) begin
              d_run_d = '0;
            end else if (d_run_q != RunMax) begin
              d_run_d = d_run_q + RunW'(1);
            end
          end else if (if_req) begin
            state_d     = StBusyI;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            cnt_d       = '0;
            d_run_d     = '0;
          end
        end
      end
      StBusyI, StBusyD: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
          if (state_q == StBusyI) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_ack_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = mem_rdata;
          end
        end else if (cnt_q == CntLast) begin
          // Abort: ack the owner with mem_err and zeroed read data.
          mem_req_d = 1'b0;
          state_d   = StIdle;
          mem_err_d = 1'b1;
          if (state_q == StBusyI) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign mem_err   = mem_err_q;
  assign busy      = (state_q != StIdle);

endmodule
